// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned Xlen               = 64;
  localparam int unsigned Ilen               = 32;
  localparam int unsigned MaxWaitDefault     = 15;
  localparam int unsigned StreakLimitDefault = 2;
  localparam int unsigned WaitCntW           = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyDm,
    StDone
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side handshake signals around the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic            if_req;
  logic [Xlen-1:0] if_addr;
  logic            if_ready;
  logic [Ilen-1:0] if_rdata;

  logic            dm_read;
  logic            dm_write;
  logic [Xlen-1:0] dm_addr;
  logic [Xlen-1:0] dm_wdata;
  logic            dm_ready;
  logic [Xlen-1:0] dm_rdata;

  logic            m_valid;
  logic            m_we;
  logic [Xlen-1:0] m_addr;
  logic [Xlen-1:0] m_wdata;
  logic            m_ack;
  logic [Xlen-1:0] m_rdata;

  logic            err;
  logic            stall_if;
  logic            stall_mem;

  // Arbiter side.
  modport master (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, m_ack, m_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata, m_valid, m_we, m_addr, m_wdata,
    output err, stall_if, stall_mem
  );

  // Pipeline and memory side.
  modport slave (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, m_ack, m_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata, m_valid, m_we, m_addr, m_wdata,
    input  err, stall_if, stall_mem
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts BUSY cycles without an ack; expired_o fires in the cycle the count reaches MaxWait.
module mem_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MaxWait = MaxWaitDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic tick_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam logic [WaitCntW-1:0] LastCnt = WaitCntW'(MaxWait - 1);

  logic [WaitCntW-1:0] cnt_q, cnt_d;

  // An ack in the final cycle takes priority over the timeout.
  assign expired_o = tick_i & ~ack_i & (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (tick_i && !ack_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, DM-priority with an
// anti-starvation streak limit for IF, and a bounded wait for the memory ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT     = MaxWaitDefault,
  parameter int unsigned STREAK_LIMIT = StreakLimitDefault
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned         StreakW   = (STREAK_LIMIT < 1) ? 1 : $clog2(STREAK_LIMIT + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STREAK_LIMIT);

  arb_state_e      state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic            m_valid_q, m_valid_d;
  logic            m_we_q, m_we_d;
  logic [Xlen-1:0] m_addr_q, m_addr_d;
  logic [Xlen-1:0] m_wdata_q, m_wdata_d;
  logic [Ilen-1:0] if_rdata_q, if_rdata_d;
  logic [Xlen-1:0] dm_rdata_q, dm_rdata_d;
  logic            if_ready_q, if_ready_d;
  logic            dm_ready_q, dm_ready_d;
  logic            err_q, err_d;

  logic dm_req;
  logic grant_if;
  logic grant_dm;
  logic busy;
  logic expired;
  logic finish;

  assign dm_req   = bus.dm_read | bus.dm_write;
  // IF only beats a pending DM request once DM has used up its streak.
  assign grant_if = (state_q == StIdle) & bus.if_req & (~dm_req | (streak_q == StreakMax));
  assign grant_dm = (state_q == StIdle) & dm_req & ~grant_if;
  assign busy     = (state_q == StBusyIf) | (state_q == StBusyDm);
  assign finish   = busy & (bus.m_ack | expired);

  mem_wait_timer #(
    .MaxWait (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .start_i   (grant_if | grant_dm),
    .tick_i    (busy),
    .ack_i     (bus.m_ack),
    .expired_o (expired)
  );

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    m_valid_d  = m_valid_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_if) begin
          state_d   = StBusyIf;
          streak_d  = '0;
          m_valid_d = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = bus.if_addr;
          m_wdata_d = '0;
        end else if (grant_dm) begin
          state_d   = StBusyDm;
          m_valid_d = 1'b1;
          m_we_d    = bus.dm_write;
          m_addr_d  = bus.dm_addr;
          m_wdata_d = bus.dm_wdata;
          if (!bus.if_req) begin
            streak_d = '0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + 1'b1;
          end
        end
      end
      StBusyIf, StBusyDm: begin
        if (finish) begin
          state_d   = StDone;
          m_valid_d = 1'b0;
          err_d     = expired;
          if (state_q == StBusyIf) begin
            if_ready_d = 1'b1;
            if_rdata_d = expired ? '0 : bus.m_rdata[Ilen-1:0];
          end else begin
            dm_ready_d = 1'b1;
            dm_rdata_d = expired ? '0 : bus.m_rdata;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      streak_q   <= '0;
      m_valid_q  <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      m_valid_q  <= m_valid_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
      err_q      <= err_d;
    end
  end

  assign bus.m_valid   = m_valid_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.err       = err_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle-by-cycle vectors plus hand-written timeout and reset sequences.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_WAIT     (15),
    .STREAK_LIMIT (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_ifr;
    logic [63:0] in_ifa;
    logic        in_dr;
    logic        in_dw;
    logic [63:0] in_da;
    logic [63:0] in_dwd;
    logic        in_ack;
    logic [63:0] in_rd;
    logic        ex_valid;
    logic        ex_we;
    logic [63:0] ex_addr;
    logic [63:0] ex_wdata;
    logic        ex_ifrdy;
    logic [31:0] ex_ifd;
    logic        ex_dmrdy;
    logic [63:0] ex_dmd;
    logic        ex_sif;
    logic        ex_smem;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ifr, input logic [63:0] ifa, input logic dr, input logic dw,
                       input logic [63:0] da, input logic [63:0] dwd, input logic ack,
                       input logic [63:0] rd);
    bus.if_req   = ifr;
    bus.if_addr  = ifa;
    bus.dm_read  = dr;
    bus.dm_write = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = dwd;
    bus.m_ack    = ack;
    bus.m_rdata  = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd1, rd2;
    rd1 = 64'h1111_2222_3333_4444;
    rd2 = 64'hAAAA_BBBB_0000_0073;
    n_checks = 0;
    n_fail   = 0;

    // IF-only fetch
    vecs.push_back('{H, 64'h100, L, L, 64'h0, 64'h0, L, 64'h0,
                     L, L, 64'h0, 64'h0, L, 32'h0, L, 64'h0, H, L});
    vecs.push_back('{H, 64'h100, L, L, 64'h0, 64'h0, H, 64'h13,
                     H, L, 64'h100, 64'h0, L, 32'h0, L, 64'h0, H, L});
    vecs.push_back('{H, 64'h100, L, L, 64'h0, 64'h0, L, 64'h0,
                     L, L, 64'h0, 64'h0, H, 32'h13, L, 64'h0, L, L});
    vecs.push_back('{L, 64'h0, L, L, 64'h0, 64'h0, L, 64'h0,
                     L, L, 64'h0, 64'h0, L, 32'h13, L, 64'h0, L, L});
    // Simultaneous IF and DM: DM first, then IF
    vecs.push_back('{H, 64'h200, H, L, 64'h3000, 64'h0, L, 64'h0,
                     L, L, 64'h0, 64'h0, L, 32'h13, L, 64'h0, H, H});
    vecs.push_back('{H, 64'h200, H, L, 64'h3000, 64'h0, H, rd1,
                     H, L, 64'h3000, 64'h0, L, 32'h13, L, 64'h0, H, H});
    vecs.push_back('{H, 64'h200, H, L, 64'h3000, 64'h0, L, 64'h0,
                     L, L, 64'h0, 64'h0, L, 32'h13, H, rd1, H, L});
    vecs.push_back('{H, 64'h200, L, L, 64'h0, 64'h0, L, 64'h0,
                     L, L, 64'h0, 64'h0, L, 32'h13, L, rd1, H, L});
    vecs.push_back('{H, 64'h200, L, L, 64'h0, 64'h0, H, rd2,
                     H, L, 64'h200, 64'h0, L, 32'h13, L, rd1, H, L});
    vecs.push_back('{H, 64'h200, L, L, 64'h0, 64'h0, L, 64'h0,
                     L, L, 64'h0, 64'h0, H, 32'h73, L, rd1, L, L});
    vecs.push_back('{L, 64'h0, L, L, 64'h0, 64'h0, L, 64'h0,
                     L, L, 64'h0, 64'h0, L, 32'h73, L, rd1, L, L});
    // Continuous DM with IF waiting: DM, DM, IF, DM (acks held high, ignored outside BUSY)
    vecs.push_back('{H, 64'h400, H, L, 64'h5000, 64'h0, H, 64'h55,
                     L, L, 64'h0, 64'h0, L, 32'h73, L, rd1, H, H});
    vecs.push_back('{H, 64'h400, H, L, 64'h5000, 64'h0, H, 64'h55,
                     H, L, 64'h5000, 64'h0, L, 32'h73, L, rd1, H, H});
    vecs.push_back('{H, 64'h400, H, L, 64'h5000, 64'h0, H, 64'h55,
                     L, L, 64'h0, 64'h0, L, 32'h73, H, 64'h55, H, L});
    vecs.push_back('{H, 64'h400, H, L, 64'h5000, 64'h0, H, 64'h66,
                     L, L, 64'h0, 64'h0, L, 32'h73, L, 64'h55, H, H});
    vecs.push_back('{H, 64'h400, H, L, 64'h5000, 64'h0, H, 64'h66,
                     H, L, 64'h5000, 64'h0, L, 32'h73, L, 64'h55, H, H});
    vecs.push_back('{H, 64'h400, H, L, 64'h5000, 64'h0, H, 64'h77,
                     L, L, 64'h0, 64'h0, L, 32'h73, H, 64'h66, H, L});
    vecs.push_back('{H, 64'h400, H, L, 64'h5000, 64'h0, H, 64'h77,
                     L, L, 64'h0, 64'h0, L, 32'h73, L, 64'h66, H, H});
    vecs.push_back('{H, 64'h400, H, L, 64'h5000, 64'h0, H, 64'h77,
                     H, L, 64'h400, 64'h0, L, 32'h73, L, 64'h66, H, H});
    vecs.push_back('{H, 64'h400, H, L, 64'h5000, 64'h0, H, 64'h88,
                     L, L, 64'h0, 64'h0, H, 32'h77, L, 64'h66, L, H});
    vecs.push_back('{H, 64'h400, H, L, 64'h5000, 64'h0, H, 64'h88,
                     L, L, 64'h0, 64'h0, L, 32'h77, L, 64'h66, H, H});
    vecs.push_back('{H, 64'h400, H, L, 64'h5000, 64'h0, H, 64'h88,
                     H, L, 64'h5000, 64'h0, L, 32'h77, L, 64'h66, H, H});
    vecs.push_back('{L, 64'h0, L, L, 64'h0, 64'h0, L, 64'h0,
                     L, L, 64'h0, 64'h0, L, 32'h77, H, 64'h88, L, L});
    // Read+write together is a store
    vecs.push_back('{L, 64'h0, H, H, 64'h2000, 64'hDEADBEEF, L, 64'h0,
                     L, L, 64'h0, 64'h0, L, 32'h77, L, 64'h88, L, H});
    vecs.push_back('{L, 64'h0, H, H, 64'h2000, 64'hDEADBEEF, L, 64'h0,
                     H, H, 64'h2000, 64'hDEADBEEF, L, 32'h77, L, 64'h88, L, H});
    vecs.push_back('{L, 64'h0, H, H, 64'h2000, 64'hDEADBEEF, H, 64'h99,
                     H, H, 64'h2000, 64'hDEADBEEF, L, 32'h77, L, 64'h88, L, H});
    vecs.push_back('{L, 64'h0, H, H, 64'h2000, 64'hDEADBEEF, L, 64'h0,
                     L, L, 64'h0, 64'h0, L, 32'h77, H, 64'h99, L, L});
    vecs.push_back('{L, 64'h0, L, L, 64'h0, 64'h0, L, 64'h0,
                     L, L, 64'h0, 64'h0, L, 32'h77, L, 64'h99, L, L});

    // Reset state
    rst = 1'b1;
    drive(L, 64'h0, L, L, 64'h0, 64'h0, L, 64'h0);
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 64'(bus.m_valid), 64'h0);
    chk("rst_m_we", 64'(bus.m_we), 64'h0);
    chk("rst_m_addr", bus.m_addr, 64'h0);
    chk("rst_m_wdata", bus.m_wdata, 64'h0);
    chk("rst_if_ready", 64'(bus.if_ready), 64'h0);
    chk("rst_dm_ready", 64'(bus.dm_ready), 64'h0);
    chk("rst_err", 64'(bus.err), 64'h0);
    chk("rst_if_rdata", 64'(bus.if_rdata), 64'h0);
    chk("rst_dm_rdata", bus.dm_rdata, 64'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in_ifr, vecs[i].in_ifa, vecs[i].in_dr, vecs[i].in_dw, vecs[i].in_da,
            vecs[i].in_dwd, vecs[i].in_ack, vecs[i].in_rd);
      @(negedge clk);
      chk($sformatf("v%0d_m_valid", i), 64'(bus.m_valid), 64'(vecs[i].ex_valid));
      if (vecs[i].ex_valid) begin
        chk($sformatf("v%0d_m_we", i), 64'(bus.m_we), 64'(vecs[i].ex_we));
        chk($sformatf("v%0d_m_addr", i), bus.m_addr, vecs[i].ex_addr);
        chk($sformatf("v%0d_m_wdata", i), bus.m_wdata, vecs[i].ex_wdata);
      end
      chk($sformatf("v%0d_if_ready", i), 64'(bus.if_ready), 64'(vecs[i].ex_ifrdy));
      chk($sformatf("v%0d_if_rdata", i), 64'(bus.if_rdata), 64'(vecs[i].ex_ifd));
      chk($sformatf("v%0d_dm_ready", i), 64'(bus.dm_ready), 64'(vecs[i].ex_dmrdy));
      chk($sformatf("v%0d_dm_rdata", i), bus.dm_rdata, vecs[i].ex_dmd);
      chk($sformatf("v%0d_err", i), 64'(bus.err), 64'h0);
      chk($sformatf("v%0d_stall_if", i), 64'(bus.stall_if), 64'(vecs[i].ex_sif));
      chk($sformatf("v%0d_stall_mem", i), 64'(bus.stall_mem), 64'(vecs[i].ex_smem));
      step();
    end

    // Timeout: no ack for 15 BUSY cycles
    drive(L, 64'h0, H, L, 64'h6000, 64'h0, L, 64'h0);
    @(negedge clk);
    chk("to_c0_m_valid", 64'(bus.m_valid), 64'h0);
    for (int k = 1; k <= 15; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("to_c%0d_m_valid", k), 64'(bus.m_valid), 64'h1);
      chk($sformatf("to_c%0d_dm_ready", k), 64'(bus.dm_ready), 64'h0);
      chk($sformatf("to_c%0d_err", k), 64'(bus.err), 64'h0);
    end
    step();
    drive(L, 64'h0, L, L, 64'h0, 64'h0, L, 64'h0);
    @(negedge clk);
    chk("to_c16_m_valid", 64'(bus.m_valid), 64'h0);
    chk("to_c16_dm_ready", 64'(bus.dm_ready), 64'h1);
    chk("to_c16_err", 64'(bus.err), 64'h1);
    chk("to_c16_dm_rdata", bus.dm_rdata, 64'h0);
    step();
    @(negedge clk);
    chk("to_c17_dm_ready", 64'(bus.dm_ready), 64'h0);
    chk("to_c17_err", 64'(bus.err), 64'h0);

    // Ack in the last allowed cycle wins over timeout
    step();
    drive(L, 64'h0, H, L, 64'h7000, 64'h0, L, 64'h0);
    for (int k = 1; k <= 14; k++) step();
    step();
    bus.m_ack   = 1'b1;
    bus.m_rdata = 64'hCAFE;
    @(negedge clk);
    chk("ack15_m_valid", 64'(bus.m_valid), 64'h1);
    chk("ack15_m_addr", bus.m_addr, 64'h7000);
    step();
    drive(L, 64'h0, L, L, 64'h0, 64'h0, L, 64'h0);
    @(negedge clk);
    chk("ack15_dm_ready", 64'(bus.dm_ready), 64'h1);
    chk("ack15_err", 64'(bus.err), 64'h0);
    chk("ack15_dm_rdata", bus.dm_rdata, 64'hCAFE);

    // Asynchronous reset during BUSY_DM, then a clean load
    step();
    step();
    drive(L, 64'h0, H, L, 64'h8000, 64'h0, L, 64'h0);
    step();
    @(negedge clk);
    chk("ar_busy_m_valid", 64'(bus.m_valid), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar_async_m_valid", 64'(bus.m_valid), 64'h0);
    chk("ar_async_m_addr", bus.m_addr, 64'h0);
    chk("ar_async_dm_ready", 64'(bus.dm_ready), 64'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("ar_hold%0d_dm_ready", k), 64'(bus.dm_ready), 64'h0);
      chk($sformatf("ar_hold%0d_m_valid", k), 64'(bus.m_valid), 64'h0);
    end
    rst = 1'b0;
    step();
    bus.m_ack   = 1'b1;
    bus.m_rdata = 64'h1234;
    @(negedge clk);
    chk("ar_regrant_m_valid", 64'(bus.m_valid), 64'h1);
    chk("ar_regrant_m_addr", bus.m_addr, 64'h8000);
    chk("ar_regrant_dm_ready", 64'(bus.dm_ready), 64'h0);
    step();
    drive(L, 64'h0, L, L, 64'h0, 64'h0, L, 64'h0);
    @(negedge clk);
    chk("ar_done_dm_ready", 64'(bus.dm_ready), 64'h1);
    chk("ar_done_dm_rdata", bus.dm_rdata, 64'h1234);
    chk("ar_done_m_valid", 64'(bus.m_valid), 64'h0);
    chk("ar_done_err", 64'(bus.err), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum BUSY cycles without m_ack before timeout (range 1..15).
REQ-002 Parameter STREAK_LIMIT, default 2: consecutive DM grants allowed while IF is waiting.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset: asynchronous, active-high.
REQ-005 if_req  in  1  fetch stage requests an instruction word; held until if_ready.
REQ-006 if_addr  in  64  fetch address.
REQ-007 if_ready  out  1  one-cycle pulse: fetch complete.
REQ-008 if_rdata  out  32  instruction; m_rdata[31:0] captured at m_ack.
REQ-009 dm_read  in  1  MEM-stage load (MemRead); held until dm_ready.
REQ-010 dm_write  in  1  MEM-stage store (MemWrite); held until dm_ready.
REQ-011 dm_addr, dm_wdata  in  64 each  data address and store data.
REQ-012 dm_ready  out  1  one-cycle pulse: load/store complete.
REQ-013 dm_rdata  out  64  load data captured at m_ack.
REQ-014 m_valid, m_we  out  1 each  memory request and write enable, registered.
REQ-015 m_addr, m_wdata  out  64 each  registered memory address and write data.
REQ-016 m_ack  in  1  memory completes the current request this cycle; m_rdata  in  64  is valid with m_ack.
REQ-017 err  out  1  one-cycle pulse, coincident with ready, on timeout.
REQ-018 stall_if, stall_mem  out  1 each  combinational pipeline stalls.

Function
REQ-019 FSM states: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE: any request -> BUSY_x.
- BUSY_x: on m_ack or timeout -> DONE.
- DONE: -> IDLE unconditionally.
REQ-020 Arbitration in IDLE: DM wins over IF, unless if_req=1 and streak==STREAK_LIMIT, in which case IF wins.
REQ-021 Streak counter:
- +1 on each DM grant made while if_req=1 (saturates at STREAK_LIMIT).
- Cleared on IF grant, and on any DM grant made while if_req=0.
REQ-022 On a grant, the edge entering BUSY_x registers m_valid=1, m_addr, and m_we/m_wdata (m_we=0 and m_wdata=0 for IF).
REQ-023 m_valid and all m_* outputs are held stable throughout BUSY_x; m_valid clears on the edge leaving BUSY_x.
REQ-024 dm_write=1 with dm_read=1 is treated as a store (m_we=1).
REQ-025 In the cycle of m_ack, the matching rdata register captures m_rdata; the ready pulse is asserted in DONE.
REQ-026 Minimum latency: request seen in IDLE cycle 0, m_ack in cycle 1, ready in cycle 2; maximum throughput is one transaction per 3 cycles.
REQ-027 Requests are ignored in DONE, so a still-high req in the ready cycle never starts a duplicate transaction.
REQ-028 Wait counter:
- Cleared on entry to BUSY_x; +1 per BUSY cycle without m_ack.
- When the count equals MAX_WAIT: m_valid clears, FSM -> DONE, ready and err pulse, rdata forced to 0.
REQ-029 If m_ack arrives in the same cycle the count reaches MAX_WAIT, m_ack wins: normal completion, no err.
REQ-030 A requester that drops its req mid-transaction does not abort it; the transaction completes and the ready pulse is still issued.
REQ-031 m_ack in IDLE or DONE is ignored.
REQ-032 stall_if = if_req & ~if_ready; stall_mem = (dm_read | dm_write) & ~dm_ready.

Reset
REQ-033 While rst=1: state=IDLE; streak and wait counters 0; m_valid, m_we, if_ready, dm_ready and err are 0; m_addr, m_wdata, if_rdata and dm_rdata are 0.
REQ-034 rst asserted mid-transaction clears m_valid immediately (asynchronously); no ready pulse is issued for the aborted transaction.
REQ-035 First arbitration occurs on the first rising edge after rst deasserts.

Structure
REQ-036 Shared package holds: the state enumeration, MAX_WAIT and STREAK_LIMIT defaults, and the XLEN=64 and ILEN=32 width constants.
REQ-037 The wait counter and timeout compare form one sub-module, mem_wait_timer (inputs: start, tick, ack; output: expired); all other logic lives in mem_port_arbiter.

Verification
REQ-038 IF only: if_addr=0x100, m_ack=1 in cycle 1 with m_rdata=0x13 -> if_ready=1 in cycle 2, if_rdata=0x00000013, stall_if=1 in cycles 0-1 only.
REQ-039 if_req and dm_read both rise in cycle 0 -> m_addr=dm_addr in cycle 1; IF granted in cycle 3 (m_addr=if_addr in cycle 4).
REQ-040 Continuous dm_read with if_req held, immediate acks -> two DM grants, then IF, then DM.
REQ-041 dm_write=dm_read=1, addr 0x2000, wdata 0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF, dm_ready after ack.
REQ-042 dm_read with no m_ack, MAX_WAIT=15 -> m_valid high for 15 cycles, then dm_ready=err=1 with dm_rdata=0; a separate run with m_ack on cycle 15 -> no err.
REQ-043 rst pulsed while in BUSY_DM -> m_valid=0 immediately, no dm_ready; a new dm_read after release completes normally.
